// File: rtl/spi_line_fetcher.sv
// Double-buffered SPI line fetcher: reads PIXELS words of PIXEL_W bits from SPI
// memory into the back bank while the front bank is read by the video side.
//
// state   | meaning
// S_IDLE  | waiting for start; swap toggles front_bank directly
// S_CMD   | shifting out the 8-bit read opcode
// S_ADDR  | shifting out the ADDR_W-bit start address
// S_DUMMY | DUMMY idle SCLK cycles (skipped when DUMMY == 0)
// S_DATA  | shifting pixel words in from MISO into the fill bank
// S_END   | one-cycle done pulse; deferred swap is applied on leaving
module spi_line_fetcher #(
  parameter int          ADDR_W  = 24,
  parameter int          PIXEL_W = 9,
  parameter int          PIXELS  = 16,
  parameter logic [7:0]  CMD     = 8'h03,
  parameter int          DUMMY   = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          addr,
  input  logic                       swap,
  input  logic [$clog2(PIXELS)-1:0]  rd_idx,
  output logic [PIXEL_W-1:0]         rd_data,
  output logic                       front_bank,
  output logic                       busy,
  output logic                       done,
  output logic                       spi_cs,
  output logic                       spi_sclk,
  output logic                       spi_mosi,
  input  logic                       spi_miso
);

  localparam int IDX_W = $clog2(PIXELS);
  localparam int TX_W  = 8 + ADDR_W;
  localparam int MAXB  = (ADDR_W > DUMMY) ? ((ADDR_W > 8) ? ADDR_W : 8)
                                          : ((DUMMY > 8) ? DUMMY : 8);
  localparam int CNT_W = $clog2(MAXB);
  localparam int PW_W  = $clog2(PIXEL_W);
  localparam logic [IDX_W:0] PIX_LIM = (IDX_W+1)'(PIXELS);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_END} state_t;

  state_t             state;
  logic [TX_W-2:0]    tx_sr;
  logic [PIXEL_W-2:0] rx_sr;
  logic [PIXEL_W-1:0] rx_next;
  logic [CNT_W-1:0]   bit_cnt;
  logic [PW_W-1:0]    pix_cnt;
  logic [IDX_W-1:0]   word_idx;
  logic               fill_bank;
  logic               swap_pending;
  logic               fb_eff;

  logic               wr_en;
  logic               wr_bank;
  logic [IDX_W-1:0]   wr_idx;
  logic [PIXEL_W-1:0] wr_data;

  logic [PIXEL_W-1:0] mem0 [PIXELS];
  logic [PIXEL_W-1:0] mem1 [PIXELS];

  always_comb begin
    rx_next = {rx_sr, spi_miso};
    fb_eff  = front_bank ^ (swap && state == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      tx_sr        <= '0;
      rx_sr        <= '0;
      bit_cnt      <= '0;
      pix_cnt      <= '0;
      word_idx     <= '0;
      fill_bank    <= 1'b0;
      swap_pending <= 1'b0;
      front_bank   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      spi_cs       <= 1'b0;
      spi_sclk     <= 1'b0;
      spi_mosi     <= 1'b0;
      wr_en        <= 1'b0;
      wr_bank      <= 1'b0;
      wr_idx       <= '0;
      wr_data      <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          front_bank <= fb_eff;
          if (start) begin
            // fill target accounts for a swap taken on this same edge
            fill_bank <= ~fb_eff;
            tx_sr     <= {CMD[6:0], addr};
            spi_mosi  <= CMD[7];
            spi_cs    <= 1'b1;
            spi_sclk  <= 1'b0;
            busy      <= 1'b1;
            bit_cnt   <= CNT_W'(7);
            pix_cnt   <= PW_W'(PIXEL_W-1);
            word_idx  <= '0;
            state     <= S_CMD;
          end
        end
        S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
          if (swap) swap_pending <= 1'b1;
          if (!spi_sclk) begin
            spi_sclk <= 1'b1;
          end else begin
            spi_sclk <= 1'b0;
            case (state)
              S_CMD: begin
                tx_sr    <= tx_sr << 1;
                spi_mosi <= tx_sr[TX_W-2];
                if (bit_cnt == '0) begin
                  bit_cnt <= CNT_W'(ADDR_W-1);
                  state   <= S_ADDR;
                end else begin
                  bit_cnt <= bit_cnt - 1'b1;
                end
              end
              S_ADDR: begin
                tx_sr <= tx_sr << 1;
                if (bit_cnt == '0) begin
                  spi_mosi <= 1'b0;
                  bit_cnt  <= CNT_W'((DUMMY > 0) ? DUMMY-1 : 0);
                  state    <= (DUMMY > 0) ? S_DUMMY : S_DATA;
                end else begin
                  spi_mosi <= tx_sr[TX_W-2];
                  bit_cnt  <= bit_cnt - 1'b1;
                end
              end
              S_DUMMY: begin
                if (bit_cnt == '0) state <= S_DATA;
                else               bit_cnt <= bit_cnt - 1'b1;
              end
              default: begin
                rx_sr <= rx_next[PIXEL_W-2:0];
                if (pix_cnt == '0) begin
                  wr_en    <= 1'b1;
                  wr_bank  <= fill_bank;
                  wr_idx   <= word_idx;
                  wr_data  <= rx_next;
                  pix_cnt  <= PW_W'(PIXEL_W-1);
                  word_idx <= word_idx + IDX_W'(1);
                  if (word_idx == IDX_W'(PIXELS-1)) begin
                    spi_cs <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= S_END;
                  end
                end else begin
                  pix_cnt <= pix_cnt - 1'b1;
                end
              end
            endcase
          end
        end
        S_END: begin
          done         <= 1'b0;
          swap_pending <= 1'b0;
          if (swap_pending || swap) front_bank <= ~front_bank;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // the last word lands on the same edge that leaves S_END
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bank) mem1[wr_idx] <= wr_data;
      else         mem0[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                         rd_data <= '0;
    else if ({1'b0, rd_idx} >= PIX_LIM) rd_data <= '0;
    else if (front_bank)               rd_data <= mem1[rd_idx];
    else                               rd_data <= mem0[rd_idx];
  end

endmodule

// File: tb/tb_spi_line_fetcher.sv
// Directed bench for spi_line_fetcher: SPI memory model, MOSI capture, timing
// of done, deferred swap, mid-fetch reset and a fast-read (dummy cycle) variant.
module tb_spi_line_fetcher;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        a_start, a_swap, a_busy, a_done, a_cs, a_sclk, a_mosi, a_front;
  logic        a_miso = 1'b0;
  logic [23:0] a_addr;
  logic [3:0]  a_rd_idx;
  logic [8:0]  a_rd_data;

  logic        b_start, b_swap, b_busy, b_done, b_cs, b_sclk, b_mosi, b_front;
  logic [23:0] b_addr;
  logic [3:0]  b_rd_idx;
  logic [8:0]  b_rd_data;

  spi_line_fetcher dut_a (
    .clk(clk), .reset(reset), .start(a_start), .addr(a_addr), .swap(a_swap),
    .rd_idx(a_rd_idx), .rd_data(a_rd_data), .front_bank(a_front), .busy(a_busy),
    .done(a_done), .spi_cs(a_cs), .spi_sclk(a_sclk), .spi_mosi(a_mosi),
    .spi_miso(a_miso)
  );

  spi_line_fetcher #(.CMD(8'h0B), .DUMMY(8)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .addr(b_addr), .swap(b_swap),
    .rd_idx(b_rd_idx), .rd_data(b_rd_data), .front_bank(b_front), .busy(b_busy),
    .done(b_done), .spi_cs(b_cs), .spi_sclk(b_sclk), .spi_mosi(b_mosi),
    .spi_miso(1'b1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // SPI memory model for dut_a: word k returns k ^ data_xor, MSB first
  logic [8:0]  data_xor = '0;
  int          rise_a = 0;
  logic        hist_a [200];
  always @(posedge a_cs or posedge a_sclk) begin
    if (!a_sclk) begin
      rise_a = 0;
    end else begin
      int idx;
      logic [8:0] w;
      if (rise_a < 200) hist_a[rise_a] = a_mosi;
      idx = rise_a - 32;
      if (idx >= 0 && idx < 144) begin
        w = 9'(idx / 9) ^ data_xor;
        a_miso = w[8 - (idx % 9)];
      end else begin
        a_miso = 1'b0;
      end
      rise_a++;
    end
  end

  int   rise_b = 0;
  logic hist_b [200];
  always @(posedge b_cs or posedge b_sclk) begin
    if (!b_sclk) begin
      rise_b = 0;
    end else begin
      if (rise_b < 200) hist_b[rise_b] = b_mosi;
      rise_b++;
    end
  end

  task automatic run_fetch(input logic [23:0] a, input int swap1, input int swap2,
                           input int restart, output int lat, output int fb_bad,
                           output logic busy_at_done, output logic fb_at_done);
    logic fb0;
    int   n;
    fb0     = a_front;
    fb_bad  = 0;
    n       = 0;
    a_addr  = a;
    a_start = 1'b1;
    forever begin
      @(posedge clk); #1;
      n++;
      a_start = 1'b0;
      a_swap  = 1'b0;
      if (n == swap1 || n == swap2) a_swap = 1'b1;
      if (n == restart) begin a_start = 1'b1; a_addr = 24'hFFFFFF; end
      if (a_front !== fb0) fb_bad++;
      if (a_done || n >= 1000) break;
    end
    a_start      = 1'b0;
    a_swap       = 1'b0;
    lat          = n;
    busy_at_done = a_busy;
    fb_at_done   = a_front;
  endtask

  task automatic check_header(input string tag, input logic [7:0] cmd, input logic [23:0] ad);
    logic [7:0]  c;
    logic [23:0] x;
    c = '0;
    x = '0;
    for (int i = 0; i < 8; i++)  c = {c[6:0], hist_a[i]};
    for (int i = 8; i < 32; i++) x = {x[22:0], hist_a[i]};
    check({tag, "_cmd"}, 32'(c), 32'(cmd));
    check({tag, "_addr"}, 32'(x), 32'(ad));
  endtask

  task automatic read_a(input string tag, input int k, input logic [8:0] exp);
    a_rd_idx = 4'(k);
    @(posedge clk); #1;
    check(tag, 32'(a_rd_data), 32'(exp));
  endtask

  initial begin
    int   lat, fb_bad, bad, dones, n;
    logic bsy, fbd;
    logic [7:0]  c;
    logic [23:0] x;

    reset = 1'b1;
    a_start = 0; a_swap = 0; a_addr = '0; a_rd_idx = '0;
    b_start = 0; b_swap = 0; b_addr = '0; b_rd_idx = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_rd_data", 32'(a_rd_data), 0);
    check("rst_done", 32'(a_done), 0);

    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (a_cs || a_sclk || a_mosi || a_busy || a_front || a_done) bad++;
    end
    check("idle_20", 32'(bad), 0);

    // slow read, words 0..15 into bank 1
    data_xor = 9'h000;
    run_fetch(24'h012345, 0, 0, 0, lat, fb_bad, bsy, fbd);
    check("f1_latency", 32'(lat), 353);
    check("f1_busy_at_done", 32'(bsy), 0);
    check("f1_sclk_rises", 32'(rise_a), 176);
    check("f1_front_steady", 32'(fb_bad), 0);
    check_header("f1", 8'h03, 24'h012345);
    @(posedge clk); #1;
    check("f1_no_auto_swap", 32'(a_front), 0);

    a_swap = 1'b1;
    @(posedge clk); #1;
    a_swap = 1'b0;
    check("swap_idle", 32'(a_front), 1);
    for (int k = 0; k < 16; k++) read_a("f1_rd", k, 9'(k));

    // swaps while busy defer and collapse; a restart mid-fetch is ignored
    data_xor = 9'h1A5;
    run_fetch(24'hABCDEF, 100, 200, 50, lat, fb_bad, bsy, fbd);
    check("f2_latency", 32'(lat), 353);
    check("f2_sclk_rises", 32'(rise_a), 176);
    check("f2_front_held", 32'(fb_bad), 0);
    check("f2_front_at_done", 32'(fbd), 1);
    check_header("f2", 8'h03, 24'hABCDEF);
    @(posedge clk); #1;
    check("f2_swap_after_done", 32'(a_front), 0);
    @(posedge clk); #1;
    check("f2_single_toggle", 32'(a_front), 0);
    read_a("f2_rd0", 0, 9'h1A5);
    read_a("f2_rd5", 5, 9'h1A0);

    // reset at cycle 150 of a fetch, with a pending swap
    data_xor = 9'h0F0;
    a_addr  = 24'h000100;
    a_start = 1'b1;
    n = 0;
    repeat (150) begin
      @(posedge clk); #1;
      n++;
      a_start = 1'b0;
      a_swap  = (n == 100);
    end
    a_swap = 1'b0;
    reset  = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_cs", 32'(a_cs), 0);
    check("rst_mid_sclk", 32'(a_sclk), 0);
    check("rst_mid_busy", 32'(a_busy), 0);
    dones = 0;
    repeat (400) begin
      @(posedge clk); #1;
      if (a_done || a_cs) dones++;
    end
    check("rst_mid_no_done", 32'(dones), 0);

    run_fetch(24'h000100, 0, 0, 0, lat, fb_bad, bsy, fbd);
    check("f3_latency", 32'(lat), 353);
    check_header("f3", 8'h03, 24'h000100);
    @(posedge clk); #1;
    check("f3_pending_cleared", 32'(a_front), 0);
    read_a("f3_bank0_kept", 3, 9'h1A6);
    a_swap = 1'b1;
    @(posedge clk); #1;
    a_swap = 1'b0;
    read_a("f3_rd7", 7, 9'h0F7);

    // fast read with 8 dummy cycles, MISO held high
    b_addr  = 24'h00ABCD;
    b_start = 1'b1;
    n = 0;
    forever begin
      @(posedge clk); #1;
      n++;
      b_start = 1'b0;
      if (b_done || n >= 1000) break;
    end
    check("fr_latency", 32'(n), 369);
    check("fr_sclk_rises", 32'(rise_b), 184);
    c = '0;
    x = '0;
    for (int i = 0; i < 8; i++)  c = {c[6:0], hist_b[i]};
    for (int i = 8; i < 32; i++) x = {x[22:0], hist_b[i]};
    check("fr_cmd", 32'(c), 32'h0B);
    check("fr_addr", 32'(x), 32'h00ABCD);
    bad = 0;
    for (int i = 32; i < 40; i++) if (hist_b[i] !== 1'b0) bad++;
    check("fr_dummy_mosi", 32'(bad), 0);
    b_swap = 1'b1;
    @(posedge clk); #1;
    b_swap   = 1'b0;
    b_rd_idx = 4'd2;
    @(posedge clk); #1;
    check("fr_rd2", 32'(b_rd_data), 32'h1FF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
